os_detector_gen12: RTL and testbench

- Gen1/Gen2 (8b/10b) receive-side ordered-set detector sitting directly upstream of the descrambler controller.
- Scans PIPE RX symbols (lane 0 = rx_data[7:0] = earliest symbol) for COM, classifies the ordered set (TS1, TS2, SKP, EIOS, FTS) and flags malformed sets.
- Drives OS_detection into the descrambler controller, together with a one-cycle-delayed copy of the data so that pulse and data stay aligned.

---
 rtl/pcie_os_pkg.sv | 56 +++++
 rtl/os_detector_gen12_if.sv | 12 +
 rtl/os_sym_decode.sv | 31 +++
 rtl/os_detector_gen12.sv | 199 +++++++++++++++++++
 tb/tb_os_detector_gen12.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pcie_os_pkg.sv
// Gen1/Gen2 ordered-set detector: shared symbol codes, type and state encodings.
// Imported by the decoder, the interface user and the detector top.
package pcie_os_pkg;

   localparam logic [7:0] K_COM = 8'hBC;
   localparam logic [7:0] K_SKP = 8'h1C;
   localparam logic [7:0] K_FTS = 8'h3C;
   localparam logic [7:0] K_IDL = 8'h7C;
   localparam logic [7:0] K_PAD = 8'hF7;
   localparam logic [7:0] D_TS1 = 8'h4A;
   localparam logic [7:0] D_TS2 = 8'h45;

   typedef enum logic [2:0] {
      OS_NONE = 3'd0,
      OS_TS1  = 3'd1,
      OS_TS2  = 3'd2,
      OS_SKP  = 3'd3,
      OS_EIOS = 3'd4,
      OS_FTS  = 3'd5
   } os_type_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TYPE,
      S_SKPS,
      S_FTSS,
      S_EI,
      S_TS
   } os_state_e;

   typedef struct packed {
      logic com;
      logic skp;
      logic fts;
      logic idl;
      logic pad;
      logic ts1id;
      logic ts2id;
      logic data;
      logic otherk;
   } sym_t;

   typedef struct packed {
      logic     v;
      os_type_e t;
   } os_done_t;

   function automatic int act_lanes(input logic [5:0] pw);
      unique case (pw)
         6'd16:   return 2;
         6'd32:   return 4;
         default: return 1;
      endcase
   endfunction

endpackage

// File: rtl/os_detector_gen12_if.sv
// PIPE receive symbol bus feeding the ordered-set detector.
// The PHY side drives it as master, the detector consumes it as slave.
interface os_detector_gen12_if #(
   parameter int MAXW = 32
);
   logic [MAXW-1:0]   rx_data;
   logic [MAXW/8-1:0] rx_datak;
   logic              rx_valid;

   modport master (output rx_data, rx_datak, rx_valid);
   modport slave  (input  rx_data, rx_datak, rx_valid);
endinterface

// File: rtl/os_sym_decode.sv
// Per-lane symbol classifier: {datak, data} to a one-hot symbol class.
// Purely combinational, one instance per lane.
module os_sym_decode
   import pcie_os_pkg::*;
(
   input  logic [7:0] data,
   input  logic       datak,
   output sym_t       sym
);

   always_comb begin
      sym = '0;
      if (datak) begin
         unique case (data)
            K_COM:   sym.com    = 1'b1;
            K_SKP:   sym.skp    = 1'b1;
            K_FTS:   sym.fts    = 1'b1;
            K_IDL:   sym.idl    = 1'b1;
            K_PAD:   sym.pad    = 1'b1;
            default: sym.otherk = 1'b1;
         endcase
      end else begin
         unique case (data)
            D_TS1:   sym.ts1id = 1'b1;
            D_TS2:   sym.ts2id = 1'b1;
            default: sym.data  = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/os_detector_gen12.sv
// Gen1/Gen2 receive ordered-set detector ahead of the descrambler controller.
// Lanes are walked serially each cycle; results are registered with the data.
module os_detector_gen12
   import pcie_os_pkg::*;
#(
   parameter int MAXW = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          GEN,
   input  logic [5:0]          PIPEWIDTH,
   os_detector_gen12_if.slave  rx,
   output logic [MAXW-1:0]     data_out,
   output logic [MAXW/8-1:0]   datak_out,
   output logic                valid_out,
   output logic                OS_detection,
   output logic                lfsr_reset,
   output logic                os_done,
   output logic [2:0]          os_type,
   output logic                os_error
);

   localparam int LANES = MAXW / 8;

   sym_t           sym [LANES];
   logic [LANES:0] skp_v;

   for (genvar g = 0; g < LANES; g++) begin : g_dec
      os_sym_decode u_dec (
         .data  (rx.rx_data[8*g +: 8]),
         .datak (rx.rx_datak[g]),
         .sym   (sym[g])
      );
      assign skp_v[g] = sym[g].skp;
   end
   assign skp_v[LANES] = 1'b0;

   os_state_e state_q, st;
   logic [1:0] cnt_q, cnt;
   logic [3:0] idx_q, idx;
   logic       ts2_q, ts2;
   os_done_t   pend_q, pend_n, d0, d1;
   logic       det, lfsr, err, dn, ok, retry, active, done_n;
   os_type_e   dt;
   logic [2:0] type_n;
   sym_t       s;
   int         nl;

   always_comb begin
      st     = state_q;
      cnt    = cnt_q;
      idx    = idx_q;
      ts2    = ts2_q;
      det    = 1'b0;
      lfsr   = 1'b0;
      err    = 1'b0;
      d0     = '0;
      d1     = '0;
      dn     = 1'b0;
      dt     = OS_NONE;
      ok     = 1'b0;
      retry  = 1'b0;
      s      = '0;
      active = (GEN == 3'd1) || (GEN == 3'd2);
      nl     = act_lanes(PIPEWIDTH);
      for (int i = 0; i < LANES; i++) begin
         if (active && rx.rx_valid && i < nl) begin
            s     = sym[i];
            dn    = 1'b0;
            dt    = OS_NONE;
            ok    = 1'b0;
            retry = 1'b0;
            unique case (st)
               S_IDLE: retry = 1'b1;
               S_TYPE: begin
                  if (s.skp) st = S_SKPS;
                  else if (s.fts) begin
                     st  = S_FTSS;
                     cnt = 2'd2;
                  end else if (s.idl) begin
                     st  = S_EI;
                     cnt = 2'd2;
                  end else if (s.data | s.pad | s.ts1id | s.ts2id) begin
                     st  = S_TS;
                     idx = 4'd2;
                  end else begin
                     err   = 1'b1;
                     st    = S_IDLE;
                     retry = 1'b1;
                  end
               end
               S_SKPS: begin
                  if (!s.skp) begin
                     dn    = 1'b1;
                     dt    = OS_SKP;
                     st    = S_IDLE;
                     retry = 1'b1;
                  end
               end
               S_FTSS, S_EI: begin
                  ok = (st == S_FTSS) ? s.fts : s.idl;
                  if (!ok) begin
                     err   = 1'b1;
                     st    = S_IDLE;
                     retry = 1'b1;
                  end else if (cnt == 2'd3) begin
                     dn = 1'b1;
                     dt = (st == S_FTSS) ? OS_FTS : OS_EIOS;
                     st = S_IDLE;
                  end else begin
                     cnt = cnt + 2'd1;
                  end
               end
               S_TS: begin
                  if (idx < 4'd6) begin
                     ok = s.data | s.pad | s.ts1id | s.ts2id;
                  end else if (idx == 4'd6) begin
                     ok  = s.ts1id | s.ts2id;
                     ts2 = s.ts2id;
                  end else begin
                     ok = ts2 ? s.ts2id : s.ts1id;
                  end
                  if (!ok) begin
                     err   = 1'b1;
                     st    = S_IDLE;
                     retry = 1'b1;
                  end else if (idx == 4'd15) begin
                     dn = 1'b1;
                     dt = ts2 ? OS_TS2 : OS_TS1;
                     st = S_IDLE;
                  end else begin
                     idx = idx + 4'd1;
                  end
               end
               default: st = S_IDLE;
            endcase
            // a COM ending or breaking a set is taken again as a fresh start
            if (retry && s.com) st = S_TYPE;
            if (s.com) begin
               det = 1'b1;
               // SKP can only be seen when it shares the word with its COM
               if (!(i + 1 < nl && skp_v[i+1])) lfsr = 1'b1;
            end
            if (dn) begin
               if (!d0.v) d0 = '{v: 1'b1, t: dt};
               else       d1 = '{v: 1'b1, t: dt};
            end
         end
      end
      if (!active) st = S_IDLE;
      if (pend_q.v) begin
         done_n = 1'b1;
         type_n = pend_q.t;
         pend_n = d0;
      end else begin
         done_n = d0.v;
         type_n = d0.v ? d0.t : OS_NONE;
         pend_n = d1;
      end
      if (!active) begin
         done_n = 1'b0;
         type_n = 3'd0;
         pend_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         idx_q        <= 4'd0;
         ts2_q        <= 1'b0;
         pend_q       <= '0;
         data_out     <= '0;
         datak_out    <= '0;
         valid_out    <= 1'b0;
         OS_detection <= 1'b0;
         lfsr_reset   <= 1'b0;
         os_done      <= 1'b0;
         os_type      <= 3'd0;
         os_error     <= 1'b0;
      end else begin
         state_q      <= st;
         cnt_q        <= cnt;
         idx_q        <= idx;
         ts2_q        <= ts2;
         pend_q       <= pend_n;
         data_out     <= rx.rx_data;
         datak_out    <= rx.rx_datak;
         valid_out    <= rx.rx_valid;
         OS_detection <= det;
         lfsr_reset   <= lfsr;
         os_done      <= done_n;
         os_type      <= type_n;
         os_error     <= err;
      end
   end

endmodule

// File: tb/tb_os_detector_gen12.sv
// Scoreboard bench for the Gen1/Gen2 ordered-set detector.
// Each driven word pushes the outputs expected on the following cycle.
module tb_os_detector_gen12;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  GEN;
   logic [5:0]  PIPEWIDTH;
   logic [31:0] data_out;
   logic [3:0]  datak_out;
   logic        valid_out;
   logic        OS_detection;
   logic        lfsr_reset;
   logic        os_done;
   logic [2:0]  os_type;
   logic        os_error;

   always #5 clk = ~clk;

   os_detector_gen12_if rx_if ();

   os_detector_gen12 dut (
      .clk          (clk),
      .reset        (reset),
      .GEN          (GEN),
      .PIPEWIDTH    (PIPEWIDTH),
      .rx           (rx_if),
      .data_out     (data_out),
      .datak_out    (datak_out),
      .valid_out    (valid_out),
      .OS_detection (OS_detection),
      .lfsr_reset   (lfsr_reset),
      .os_done      (os_done),
      .os_type      (os_type),
      .os_error     (os_error)
   );

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        v;
      logic        det;
      logic        lfsr;
      logic        done;
      logic [2:0]  t;
      logic        err;
   } exp_t;

   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   string phase  = "rst";
   int    stepno = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s.%0d.%s got %0h expected %0h",
                  phase, stepno, tag, got, exp);
      end
   endtask

   task automatic step(input logic rst, input logic [31:0] d,
                       input logic [3:0] k, input logic v,
                       input logic det, input logic lfsr,
                       input logic done, input logic [2:0] t,
                       input logic err);
      exp_t e;
      reset             = rst;
      rx_if.rx_data     = d;
      rx_if.rx_datak    = k;
      rx_if.rx_valid    = v;
      e.d    = rst ? 32'd0 : d;
      e.k    = rst ? 4'd0 : k;
      e.v    = rst ? 1'b0 : v;
      e.det  = det;
      e.lfsr = lfsr;
      e.done = done;
      e.t    = t;
      e.err  = err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("data",  data_out, e.d);
      check("datak", 32'(datak_out), 32'(e.k));
      check("valid", 32'(valid_out), 32'(e.v));
      check("det",   32'(OS_detection), 32'(e.det));
      check("lfsr",  32'(lfsr_reset), 32'(e.lfsr));
      check("done",  32'(os_done), 32'(e.done));
      check("type",  32'(os_type), 32'(e.t));
      check("err",   32'(os_error), 32'(e.err));
      stepno++;
   endtask

   initial begin
      reset          = 1'b1;
      GEN            = 3'd1;
      PIPEWIDTH      = 6'd8;
      rx_if.rx_data  = '0;
      rx_if.rx_datak = '0;
      rx_if.rx_valid = 1'b0;

      step(1, 32'h7C7C7CBC, 4'hF, 1, 0, 0, 0, 0, 0);
      step(1, 32'h1C1C1CBC, 4'hF, 1, 0, 0, 0, 0, 0);

      // 8-bit TS1; upper lanes carry COMs that must be ignored
      phase = "ts1";
      step(0, 32'hBCBCBCBC, 4'hF, 1, 1, 1, 0, 0, 0);
      step(0, 32'hBCBCBCF7, 4'hF, 1, 0, 0, 0, 0, 0);
      step(0, 32'hBCBCBCF7, 4'hF, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 32'hBCBCBC00, 4'hE, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         step(0, 32'hBCBCBC4A, 4'hE, 1, 0, 0, i == 9,
              (i == 9) ? 3'd1 : 3'd0, 0);
      step(0, 32'h00000000, 4'h0, 1, 0, 0, 0, 0, 0);

      phase = "skp16";
      PIPEWIDTH = 6'd16;
      GEN       = 3'd2;
      step(0, 32'h00001CBC, 4'h3, 1, 1, 0, 0, 0, 0);
      step(0, 32'h00001C1C, 4'h3, 1, 0, 0, 0, 0, 0);
      step(0, 32'h00002211, 4'h0, 1, 0, 0, 1, 3'd3, 0);

      phase = "eios32";
      PIPEWIDTH = 6'd32;
      GEN       = 3'd1;
      step(0, 32'h7C7C7CBC, 4'hF, 1, 1, 1, 1, 3'd4, 0);

      phase = "pend";
      step(0, 32'h1C1C1CBC, 4'hF, 1, 1, 0, 0, 0, 0);
      step(0, 32'h7C7C7CBC, 4'hF, 1, 1, 1, 1, 3'd3, 0);
      step(0, 32'h00000000, 4'h0, 1, 0, 0, 1, 3'd4, 0);

      phase = "tserr";
      step(0, 32'h000001BC, 4'h1, 1, 1, 1, 0, 0, 0);
      step(0, 32'hBCBCBCBC, 4'hF, 0, 0, 0, 0, 0, 0);
      step(0, 32'h4A4A0000, 4'h0, 1, 0, 0, 0, 0, 0);
      step(0, 32'h4A4A454A, 4'h0, 1, 0, 0, 0, 0, 1);
      step(0, 32'h3C3C3CBC, 4'hF, 1, 1, 1, 1, 3'd5, 0);

      phase = "gen3";
      GEN = 3'd3;
      step(0, 32'h7C7C7CBC, 4'hF, 1, 0, 0, 0, 0, 0);
      step(0, 32'h1C1C1CBC, 4'hF, 1, 0, 0, 0, 0, 0);

      phase = "rstmid";
      GEN = 3'd1;
      step(0, 32'h000001BC, 4'h1, 1, 1, 1, 0, 0, 0);
      step(0, 32'h4A4A0000, 4'h0, 1, 0, 0, 0, 0, 0);
      step(1, 32'h4A4A4A4A, 4'h0, 1, 0, 0, 0, 0, 0);
      step(0, 32'h4A4A4A4A, 4'h0, 1, 0, 0, 0, 0, 0);
      step(0, 32'h00000000, 4'h0, 1, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
